// File: rtl/ln_seq_ctrl_pkg.sv
// Shared configuration for the ln sequencer: element width, default latency,
// zero-input saturation value, FSM state encoding and per-element tag layout.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif

package ln_seq_ctrl_pkg;

  localparam int PKG_DATA_W = `OUTPUT_BUF_DATASIZE;
  localparam int PKG_LAT    = 4;
  localparam logic [PKG_DATA_W-1:0] PKG_ZERO_SAT = {1'b1, {(PKG_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Side-band bits that travel with an element through the ln pipeline
  typedef struct packed {
    logic valid;
    logic last;
    logic zero;
  } tag_t;

endpackage

// File: rtl/ln_seq_ctrl_if.sv
// Input element stream and output result stream of the ln sequencer.
interface ln_seq_ctrl_if
  import ln_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/ln_res_fifo.sv
// Synchronous result FIFO with wrap-bit pointers; no write-to-read bypass, so a
// word written into an empty FIFO becomes visible on the following cycle.
module ln_res_fifo
  import ln_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = PKG_DATA_W + 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (rd_en && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // The credit scheme upstream must make an overflowing write impossible
  assert property (@(posedge clk) disable iff (!rst) !(wr_en && full));

endmodule

// File: rtl/ln_seq_ctrl.sv
// Row sequencer for the non-stallable ln pipeline: issues one element per cycle,
// tracks in-flight tags, catches results in a credit-protected FIFO.
module ln_seq_ctrl
  import ln_seq_ctrl_pkg::*;
#(
  parameter int DATA_W     = PKG_DATA_W,
  parameter int LAT        = PKG_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8,
  parameter logic [DATA_W-1:0] ZERO_SAT = {1'b1, {(DATA_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              zero_err,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_x,
  input  logic [DATA_W-1:0] dp_res,
  ln_seq_ctrl_if.slave      bus
);

  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  issued_reg;
  logic [CRED_W-1:0] credit_reg;
  logic              dp_valid_reg, dp_last_reg, dp_zero_reg;
  logic [DATA_W-1:0] dp_x_reg;
  logic              zero_err_reg;

  logic              in_ready_c, accept, pop, issue_last;
  logic              fifo_empty, chain_busy;
  logic [DATA_W:0]   fifo_rd;
  logic [LAT-1:0]    stage_valid;
  tag_t              dp_tag, chain_tail;

  assign issue_last = (issued_reg + LEN_W'(1)) == len_reg;
  assign pop        = ~fifo_empty & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        in_ready_c = (credit_reg != '0) && (issued_reg < len_reg);
        accept     = in_ready_c & bus.in_valid;
        if (accept && issue_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!chain_busy && fifo_empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      issued_reg   <= '0;
      credit_reg   <= CRED_W'(FIFO_DEPTH);
      dp_valid_reg <= 1'b0;
      dp_last_reg  <= 1'b0;
      dp_zero_reg  <= 1'b0;
      dp_x_reg     <= '0;
      zero_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dp_valid_reg <= accept;
      if (state_reg == ST_IDLE && start) begin
        len_reg      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        issued_reg   <= '0;
        zero_err_reg <= 1'b0;
      end
      if (accept) begin
        dp_x_reg    <= bus.in_data;
        dp_last_reg <= issue_last;
        dp_zero_reg <= (bus.in_data == '0);
        issued_reg  <= issued_reg + LEN_W'(1);
        if (bus.in_data == '0) zero_err_reg <= 1'b1;
      end
      // A credit is held from issue until the matching result is popped
      case ({accept, pop})
        2'b10:   credit_reg <= credit_reg - CRED_W'(1);
        2'b01:   credit_reg <= credit_reg + CRED_W'(1);
        default: credit_reg <= credit_reg;
      endcase
    end
  end

  assign dp_valid = dp_valid_reg;
  assign dp_x     = dp_x_reg;
  assign zero_err = zero_err_reg;
  assign dp_tag   = '{valid: dp_valid_reg, last: dp_last_reg, zero: dp_zero_reg};

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_chain
      tag_t stage_reg;
      tag_t stage_in;
      if (gi == 0) begin : g_head
        assign stage_in = dp_tag;
      end else begin : g_tail
        assign stage_in = g_chain[gi-1].stage_reg;
      end
      always_ff @(posedge clk) begin
        if (!rst) stage_reg <= '0;
        else      stage_reg <= stage_in;
      end
      assign stage_valid[gi] = stage_reg.valid;
    end
  endgenerate

  // The final tag stage lines up with dp_res for the same element
  assign chain_tail = g_chain[LAT-1].stage_reg;
  assign chain_busy = dp_valid_reg | (|stage_valid);

  ln_res_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (chain_tail.valid),
    .wr_data ({chain_tail.last, chain_tail.zero ? ZERO_SAT : dp_res}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_rd[DATA_W-1:0];
  assign bus.out_last  = ~fifo_empty & fifo_rd[DATA_W];

endmodule

// File: tb/tb_ln_seq_ctrl.sv
// Directed and randomized checks of ln_seq_ctrl against a LAT-cycle x+1 pipeline model.
module tb_ln_seq_ctrl;
  import ln_seq_ctrl_pkg::*;

  localparam int DW    = PKG_DATA_W;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int LEN_W = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic             clk, rst, start, busy, done, zero_err, dp_valid;
  logic [LEN_W-1:0] cfg_len;
  logic [DW-1:0]    dp_x, dp_res, zsat;
  logic [DW-1:0]    pipe [LAT];
  logic [DW-1:0]    src [64];
  exp_t             exp_q [$];

  int total, bad, cyc, src_idx, src_n, n_acc, n_done, row_eff;
  int first_acc, last_acc, first_ov;
  bit rst_val, start_pend, drive_in, in_rand, out_rand, out_hold;

  ln_seq_ctrl_if #(.DATA_W(DW)) bus ();

  ln_seq_ctrl #(
    .DATA_W(DW), .LAT(LAT), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .busy(busy), .done(done), .zero_err(zero_err),
    .dp_valid(dp_valid), .dp_x(dp_x), .dp_res(dp_res), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= dp_x + DW'(1);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_res = pipe[LAT-1];

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    rst   = rst_val;
    start = start_pend;
    start_pend = 0;
    bus.in_valid  = drive_in && (src_idx < src_n) && (in_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    bus.in_data   = (src_idx < src_n) ? src[src_idx] : '0;
    bus.out_ready = out_rand ? ($urandom_range(0, 1) == 1) : out_hold;
    #1;
    cyc++;
    if (bus.in_valid && bus.in_ready) begin
      if (n_acc == 0) first_acc = cyc;
      last_acc = cyc;
      src_idx++;
      n_acc++;
    end
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(bus.out_data), int'(e.data));
        chk("out_last", int'(bus.out_last), int'(e.last));
      end
    end
    if (done) begin
      n_done++;
      chk("busy_at_done", int'(busy), 0);
    end
  endtask

  task automatic row_begin(input int cfg);
    exp_t e;
    row_eff = (cfg == 0) ? 1 : cfg;
    src_idx = 0; n_acc = 0; n_done = 0;
    first_acc = -1; last_acc = -1; first_ov = -1;
    for (int i = 0; i < row_eff; i++) begin
      e.data = (src[i] == '0) ? zsat : src[i] + DW'(1);
      e.last = (i == row_eff - 1);
      exp_q.push_back(e);
    end
    cfg_len = LEN_W'(cfg);
    start_pend = 1;
  endtask

  task automatic row_wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, n_done, 1);
    step();
    chk({tag, "_done_once"}, n_done, 1);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_accepts"}, n_acc, row_eff);
    exp_q.delete();
  endtask

  initial begin
    int k;
    clk = 0; rst = 0; start = 0; cfg_len = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    total = 0; bad = 0; cyc = 0; src_n = 0; src_idx = 0;
    rst_val = 0; start_pend = 0; drive_in = 1; in_rand = 0; out_rand = 0; out_hold = 1;
    zsat = '0;
    zsat[DW-1] = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_dp_valid", int'(dp_valid), 0);
    chk("rst_dp_x", int'(dp_x), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_zero_err", int'(zero_err), 0);
    rst_val = 1;
    step();

    // 1: back-to-back row of four, latency and throughput
    src[0] = 10; src[1] = 20; src[2] = 30; src[3] = 40; src_n = 4;
    row_begin(4);
    step(); step();
    chk("t1_busy", int'(busy), 1);
    row_wait_done("t1", 200);
    chk("t1_latency", first_ov - first_acc, 2 + LAT);
    chk("t1_tput", last_acc - first_acc, 3);
    chk("t1_busy_after", int'(busy), 0);

    // 2: blocked sink limits accepts to FIFO depth
    for (int i = 0; i < 16; i++) src[i] = DW'(100 + i);
    src_n = 16; out_hold = 0;
    row_begin(16);
    repeat (30) step();
    chk("t2_accepts_blocked", n_acc, DEPTH);
    chk("t2_in_ready", int'(bus.in_ready), 0);
    chk("t2_out_valid", int'(bus.out_valid), 1);
    out_hold = 1;
    row_wait_done("t2", 300);

    // 3: zero input saturates and sets sticky flag until next start
    src[0] = 5; src[1] = 0; src[2] = 7; src_n = 3;
    row_begin(3);
    row_wait_done("t3", 200);
    repeat (3) step();
    chk("t3_zero_err_held", int'(zero_err), 1);
    src[0] = 1; src[1] = 2; src_n = 2;
    row_begin(2);
    step(); step();
    chk("t3_zero_err_clear", int'(zero_err), 0);
    row_wait_done("t3b", 200);
    chk("t3_zero_err_row2", int'(zero_err), 0);

    // 6: cfg_len 0 means one element; start during RUN ignored
    src[0] = 100; src_n = 1; drive_in = 0;
    row_begin(0);
    repeat (3) step();
    chk("t6_in_ready", int'(bus.in_ready), 1);
    cfg_len = 5; start_pend = 1;
    step(); step();
    chk("t6_busy", int'(busy), 1);
    drive_in = 1;
    row_wait_done("t6", 60);
    chk("t6_in_ready_after", int'(bus.in_ready), 0);

    // 5: reset with elements in flight
    src[0] = 3; src[1] = 0; src[2] = 9; src_n = 3; out_hold = 0;
    row_begin(10);
    k = 0;
    while (n_acc < 3 && k < 50) begin step(); k++; end
    chk("t5_accepts", n_acc, 3);
    drive_in = 0; rst_val = 0;
    step(); step();
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_in_ready", int'(bus.in_ready), 0);
    chk("t5_dp_valid", int'(dp_valid), 0);
    chk("t5_dp_x", int'(dp_x), 0);
    chk("t5_out_valid", int'(bus.out_valid), 0);
    chk("t5_out_last", int'(bus.out_last), 0);
    chk("t5_zero_err", int'(zero_err), 0);
    rst_val = 1; exp_q.delete(); out_hold = 1;
    repeat (10) step();
    chk("t5_no_stale", int'(bus.out_valid), 0);
    src[0] = 50; src[1] = 60; src_n = 2; drive_in = 1;
    row_begin(2);
    row_wait_done("t5b", 200);

    // 4: random handshakes over many rows
    in_rand = 1; out_rand = 1;
    for (int r = 0; r < 100; r++) begin
      int len;
      len = $urandom_range(1, 32);
      for (int i = 0; i < len; i++)
        src[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 65535));
      src_n = len;
      row_begin(len);
      row_wait_done("t4", 600);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
